// File: rtl/instruction_memory.sv
// MEM stage: issues data-memory requests from the EX/MEM bundle, stalls
// while an access is outstanding and owns the MEM/WB pipeline register.
package instruction_memory_pkg;
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [2:0] funct3;
        logic [3:0] regfilemux_sel;
    } ctrl_t;

    typedef struct packed {
        logic        valid;
        ctrl_t       ctrl;
        logic [31:0] instr;
        logic [31:0] alu_out;
        logic [31:0] rs2_out;
        logic        br_en;
        logic [31:0] reg_out;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        ctrl_t       ctrl;
        logic [31:0] instr;
        logic [31:0] alu_out;
        logic        br_en;
        logic [31:0] reg_out;
        logic [31:0] dmem_rdata;
    } mem_wb_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_HOLD = 2'd2
    } state_t;
endpackage

module instruction_memory
    import instruction_memory_pkg::*;
#(
    parameter int MAX_WAIT    = 255,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  ex_mem_t     ex_mem,
    input  logic        stall_in,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic [31:0] dmem_address,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    output logic        mem_stall,
    output mem_wb_t     mem_wb,
    output logic        misaligned,
    output logic        dmem_timeout,
    output logic [1:0]  dbg_state_o
);
    // Handshake: a request (dmem_read/dmem_write) stays asserted with stable
    // address/mask/data until the single-cycle dmem_resp pulse; upstream
    // holds ex_mem stable while mem_stall is high.

    localparam int CW = $clog2(MAX_WAIT + 1);

    state_t      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
    mem_wb_t     mem_wb_q, mem_wb_d;

    logic [1:0]  a;
    logic        access, is_half, is_word, mis, issue;
    logic        complete, latch;
    logic [CW:0] cnt_inc;

    assign a       = ex_mem.alu_out[1:0];
    assign access  = ex_mem.valid & (ex_mem.ctrl.mem_read | ex_mem.ctrl.mem_write);
    assign is_half = (ex_mem.ctrl.funct3[1:0] == 2'b01);
    assign is_word = (ex_mem.ctrl.funct3[1:0] == 2'b10);
    assign mis     = CHECK_ALIGN & access & ((is_half & a[0]) | (is_word & (a != 2'b00)));
    assign issue   = access & ~mis;
    assign cnt_inc = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};

    // State register plus request bookkeeping (latched load data, watchdog)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            rdata_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // MEM/WB pipeline register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wb_q <= '0;
        end else begin
            mem_wb_q <= mem_wb_d;
        end
    end

    // Next-state logic; a response that lands while the pipe is frozen is
    // parked in HOLD so the request is never reissued.
    always_comb begin
        state_d  = state_q;
        complete = 1'b0;
        latch    = 1'b0;
        case (state_q)
            S_IDLE: begin
                complete = ~issue | dmem_resp;
                if (issue) begin
                    if (!dmem_resp) begin
                        state_d = S_BUSY;
                    end else if (stall_in) begin
                        state_d = S_HOLD;
                        latch   = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                complete = dmem_resp;
                if (dmem_resp) begin
                    if (stall_in) begin
                        state_d = S_HOLD;
                        latch   = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                complete = 1'b1;
                if (!stall_in) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        rdata_d = latch ? dmem_rdata : rdata_q;

        // Watchdog counts BUSY cycles, saturates, clears when BUSY is left
        cnt_d     = '0;
        timeout_d = timeout_q;
        if (state_q == S_BUSY) begin
            if (cnt_inc >= (CW+1)'(MAX_WAIT)) timeout_d = 1'b1;
            if (state_d == S_BUSY && cnt_q != CW'(MAX_WAIT)) cnt_d = cnt_inc[CW-1:0];
            else if (state_d == S_BUSY) cnt_d = cnt_q;
        end

        // MEM/WB: hold under stall_in, bubble while waiting, else advance
        mem_wb_d = mem_wb_q;
        if (!stall_in) begin
            mem_wb_d = '0;
            if (complete) begin
                mem_wb_d.valid   = ex_mem.valid;
                mem_wb_d.ctrl    = ex_mem.ctrl;
                mem_wb_d.instr   = ex_mem.instr;
                mem_wb_d.alu_out = ex_mem.alu_out;
                mem_wb_d.br_en   = ex_mem.br_en;
                mem_wb_d.reg_out = ex_mem.reg_out;
                if (issue & ex_mem.ctrl.mem_read) begin
                    mem_wb_d.dmem_rdata = (state_q == S_HOLD) ? rdata_q : dmem_rdata;
                end
            end
        end
    end

    // Outputs: requests come straight from ex_mem, which upstream holds stable
    always_comb begin
        logic req;
        req          = rst & (((state_q == S_IDLE) & issue) | (state_q == S_BUSY));
        dmem_address = {ex_mem.alu_out[31:2], 2'b00};
        dmem_wdata   = ex_mem.rs2_out << {a, 3'b000};
        dmem_read    = req & ex_mem.ctrl.mem_read;
        dmem_write   = req & ex_mem.ctrl.mem_write;
        dmem_wmask   = 4'b0000;
        if (dmem_write) begin
            case (ex_mem.ctrl.funct3[1:0])
                2'b00:   dmem_wmask = 4'b0001 << a;
                2'b01:   dmem_wmask = 4'b0011 << a;
                default: dmem_wmask = 4'b1111;
            endcase
        end
        case (state_q)
            S_IDLE:  mem_stall = rst & issue & ~dmem_resp;
            S_BUSY:  mem_stall = rst & (~dmem_resp | stall_in);
            S_HOLD:  mem_stall = rst & stall_in;
            default: mem_stall = 1'b0;
        endcase
        misaligned   = rst & (state_q == S_IDLE) & mis & ~stall_in;
        dmem_timeout = timeout_q;
        mem_wb       = mem_wb_q;
        dbg_state_o  = state_q;
    end
endmodule

// File: tb/tb_instruction_memory.sv
// Directed bench for the MEM stage: ALU pass-through, stores, loads,
// misalignment, frozen-pipe response, watchdog and asynchronous reset.
module tb_instruction_memory;
    import instruction_memory_pkg::*;

    logic        clk;
    logic        rst;
    ex_mem_t     ex_mem;
    logic        stall_in;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic [31:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic        mem_stall;
    mem_wb_t     mem_wb;
    logic        misaligned;
    logic        dmem_timeout;
    logic [1:0]  dbg_state_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    instruction_memory #(.MAX_WAIT(4), .CHECK_ALIGN(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_mem       (ex_mem),
        .stall_in     (stall_in),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .dmem_address (dmem_address),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_wmask   (dmem_wmask),
        .dmem_wdata   (dmem_wdata),
        .mem_stall    (mem_stall),
        .mem_wb       (mem_wb),
        .misaligned   (misaligned),
        .dmem_timeout (dmem_timeout),
        .dbg_state_o  (dbg_state_o)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: pops the expected load word and checks the MEM/WB entry
    task automatic chk_wb(input string tag, input logic [31:0] exp_addr);
        logic [31:0] exp_rdata;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: expected queue empty", tag);
        end else begin
            exp_rdata = exp_q.pop_front();
            chk({tag, ".valid"}, {31'd0, mem_wb.valid}, 32'd1);
            chk({tag, ".alu_out"}, mem_wb.alu_out, exp_addr);
            chk({tag, ".rdata"}, mem_wb.dmem_rdata, exp_rdata);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    function automatic ex_mem_t mk(input logic v, input logic rd, input logic wr,
                                   input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] data);
        ex_mem_t e;
        e                     = '0;
        e.valid               = v;
        e.ctrl.mem_read       = rd;
        e.ctrl.mem_write      = wr;
        e.ctrl.funct3         = f3;
        e.ctrl.regfilemux_sel = 4'd3;
        e.instr               = 32'h0000_0013 ^ addr;
        e.alu_out             = addr;
        e.rs2_out             = data;
        e.reg_out             = addr ^ 32'hFFFF_0000;
        return e;
    endfunction

    task automatic drive(input ex_mem_t e);
        ex_mem = e;
    endtask

    initial begin
        int stall_cycles;
        rst        = 1'b0;
        ex_mem     = '0;
        stall_in   = 1'b0;
        dmem_rdata = '0;
        dmem_resp  = 1'b0;

        // Reset state
        repeat (2) sample();
        chk("rst.valid", {31'd0, mem_wb.valid}, 32'd0);
        chk("rst.read", {31'd0, dmem_read}, 32'd0);
        chk("rst.write", {31'd0, dmem_write}, 32'd0);
        chk("rst.stall", {31'd0, mem_stall}, 32'd0);
        chk("rst.timeout", {31'd0, dmem_timeout}, 32'd0);
        chk("rst.state", {30'd0, dbg_state_o}, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // ALU op passes with no request and no stall
        drive(mk(1'b1, 1'b0, 1'b0, 3'b000, 32'h1234, 32'h0));
        exp_q.push_back(32'h0);
        sample();
        chk("alu.read", {31'd0, dmem_read}, 32'd0);
        chk("alu.write", {31'd0, dmem_write}, 32'd0);
        chk("alu.stall", {31'd0, mem_stall}, 32'd0);
        tick();
        chk_wb("alu.wb", 32'h1234);
        drive('0);

        // sb at offset 3, response three cycles after issue
        drive(mk(1'b1, 1'b0, 1'b1, 3'b000, 32'h1003, 32'h0000_00AB));
        exp_q.push_back(32'h0);
        stall_cycles = 0;
        sample();
        chk("sb.addr", dmem_address, 32'h1000);
        chk("sb.wmask", {28'd0, dmem_wmask}, 32'h8);
        chk("sb.wdata", dmem_wdata, 32'hAB00_0000);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) dmem_resp = 1'b1;
            if (c > 0) sample();
            if (mem_stall) stall_cycles++;
            if (c == 2) begin
                chk("sb.busy_state", {30'd0, dbg_state_o}, 32'd1);
                chk("sb.busy_write", {31'd0, dmem_write}, 32'd1);
            end
            tick();
        end
        chk("sb.stall_cycles", stall_cycles, 32'd3);
        dmem_resp = 1'b0;
        chk_wb("sb.wb", 32'h1003);
        chk("sb.idle", {30'd0, dbg_state_o}, 32'd0);
        drive('0);

        // sh at offset 2, response in the issue cycle
        drive(mk(1'b1, 1'b0, 1'b1, 3'b001, 32'h5002, 32'h0000_BEEF));
        dmem_resp = 1'b1;
        sample();
        chk("sh.wmask", {28'd0, dmem_wmask}, 32'hC);
        chk("sh.wdata", dmem_wdata, 32'hBEEF_0000);
        chk("sh.stall", {31'd0, mem_stall}, 32'd0);
        tick();
        dmem_resp = 1'b0;
        drive('0);

        // lw with same-cycle response: no stall
        drive(mk(1'b1, 1'b1, 1'b0, 3'b010, 32'h2000, 32'h0));
        dmem_resp  = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        exp_q.push_back(32'hDEAD_BEEF);
        sample();
        chk("lw.read", {31'd0, dmem_read}, 32'd1);
        chk("lw.wmask", {28'd0, dmem_wmask}, 32'h0);
        chk("lw.stall", {31'd0, mem_stall}, 32'd0);
        tick();
        dmem_resp  = 1'b0;
        dmem_rdata = 32'h0;
        drive('0);
        chk_wb("lw.wb", 32'h2000);
        tick();
        chk("lw.bubble", {31'd0, mem_wb.valid}, 32'd0);

        // Misaligned lh: suppressed, passes with zero data
        drive(mk(1'b1, 1'b1, 1'b0, 3'b001, 32'h2001, 32'h0));
        dmem_rdata = 32'h5555_5555;
        exp_q.push_back(32'h0);
        sample();
        chk("lh.misaligned", {31'd0, misaligned}, 32'd1);
        chk("lh.read", {31'd0, dmem_read}, 32'd0);
        chk("lh.stall", {31'd0, mem_stall}, 32'd0);
        tick();
        chk_wb("lh.wb", 32'h2001);
        drive('0);
        dmem_rdata = 32'h0;
        sample();
        chk("lh.pulse_end", {31'd0, misaligned}, 32'd0);
        tick();

        // lw whose response arrives while the pipe is frozen for two cycles
        drive(mk(1'b1, 1'b1, 1'b0, 3'b010, 32'h3000, 32'h0));
        exp_q.push_back(32'hCAFE_F00D);
        tick();
        dmem_resp  = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        stall_in   = 1'b1;
        sample();
        chk("hold.read_at_resp", {31'd0, dmem_read}, 32'd1);
        tick();
        dmem_resp  = 1'b0;
        dmem_rdata = 32'h0;
        sample();
        chk("hold.state", {30'd0, dbg_state_o}, 32'd2);
        chk("hold.read_dropped", {31'd0, dmem_read}, 32'd0);
        chk("hold.stall", {31'd0, mem_stall}, 32'd1);
        chk("hold.wb_frozen", {31'd0, mem_wb.valid}, 32'd0);
        tick();
        sample();
        chk("hold.read_still_low", {31'd0, dmem_read}, 32'd0);
        tick();
        stall_in = 1'b0;
        sample();
        chk("hold.release_no_req", {31'd0, dmem_read}, 32'd0);
        chk("hold.release_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        drive('0);
        chk_wb("hold.wb", 32'h3000);
        chk("hold.idle", {30'd0, dbg_state_o}, 32'd0);
        tick();

        // sw with no response: watchdog after four BUSY cycles
        drive(mk(1'b1, 1'b0, 1'b1, 3'b010, 32'h4000, 32'h1122_3344));
        sample();
        chk("sw.wmask", {28'd0, dmem_wmask}, 32'hF);
        chk("sw.wdata", dmem_wdata, 32'h1122_3344);
        repeat (4) tick();
        sample();
        chk("wd.before", {31'd0, dmem_timeout}, 32'd0);
        tick();
        sample();
        chk("wd.set", {31'd0, dmem_timeout}, 32'd1);
        chk("wd.not_aborted", {31'd0, dmem_write}, 32'd1);
        tick();
        sample();
        chk("wd.sticky", {31'd0, dmem_timeout}, 32'd1);

        // Asynchronous reset in the middle of BUSY
        #2;
        rst = 1'b0;
        #1;
        chk("arst.write", {31'd0, dmem_write}, 32'd0);
        chk("arst.wmask", {28'd0, dmem_wmask}, 32'h0);
        chk("arst.stall", {31'd0, mem_stall}, 32'd0);
        chk("arst.timeout", {31'd0, dmem_timeout}, 32'd0);
        chk("arst.state", {30'd0, dbg_state_o}, 32'd0);
        chk("arst.valid", {31'd0, mem_wb.valid}, 32'd0);
        drive('0);
        tick();
        rst = 1'b1;
        sample();
        chk("post.write", {31'd0, dmem_write}, 32'd0);
        chk("post.queue", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
